// File: rtl/rmio_pkg.sv
// Shared RMIO link constants: default word width, FIFO depths and count-width helper.
package rmio_pkg;

   localparam int unsigned RMIO_DATA_W    = 32;
   localparam int unsigned RMIO_IN_DEPTH  = 16;
   localparam int unsigned RMIO_OUT_DEPTH = 16;

   // Occupancy counters must represent 0..DEPTH inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   localparam int unsigned RMIO_CNT_W = cnt_w(RMIO_IN_DEPTH);

endpackage

// File: rtl/rmio_sync_fifo.sv
// First-word-fall-through synchronous FIFO with separate occupancy count.
module rmio_sync_fifo
   import rmio_pkg::*;
#(
   parameter int unsigned W     = RMIO_DATA_W,
   parameter int unsigned DEPTH = RMIO_IN_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [cnt_w(DEPTH)-1:0]  count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= push_data;
   end

   assign head  = mem[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/rmio_eu_buffer.sv
// EU-side RMIO endpoint: input FIFO feeds the EU operand stream, output FIFO returns results.
module rmio_eu_buffer
   import rmio_pkg::*;
#(
   parameter int unsigned DATA_W    = RMIO_DATA_W,
   parameter int unsigned IN_DEPTH  = RMIO_IN_DEPTH,
   parameter int unsigned OUT_DEPTH = RMIO_OUT_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_W-1:0]            input_data,
   input  logic                         input_we,
   input  logic                         output_re,
   output logic [DATA_W-1:0]            output_data,
   output logic [DATA_W-1:0]            op_data,
   output logic                         op_valid,
   input  logic                         op_ready,
   input  logic [DATA_W-1:0]            res_data,
   input  logic                         res_valid,
   output logic                         res_ready,
   output logic [cnt_w(IN_DEPTH)-1:0]   in_count,
   output logic [cnt_w(OUT_DEPTH)-1:0]  out_count,
   output logic                         err_ovf,
   output logic                         err_udf,
   input  logic                         clr_err
);

   logic              in_full;
   logic              in_empty;
   logic              in_pop;
   logic              ovf_set;
   logic              out_full;
   logic              out_empty;
   logic              out_push;
   logic              out_pop;
   logic              udf_set;
   logic [DATA_W-1:0] out_head;

   assign op_valid = !in_empty;
   assign in_pop   = op_valid && op_ready;
   assign ovf_set  = input_we && in_full && !in_pop;

   rmio_sync_fifo #(
      .W     (DATA_W),
      .DEPTH (IN_DEPTH)
   ) u_in_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (input_we),
      .push_data (input_data),
      .pop       (in_pop),
      .head      (op_data),
      .full      (in_full),
      .empty     (in_empty),
      .count     (in_count)
   );

   assign res_ready = !out_full;
   assign out_push  = res_valid && res_ready;
   assign out_pop   = output_re && !out_empty;
   assign udf_set   = output_re && out_empty;

   rmio_sync_fifo #(
      .W     (DATA_W),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (out_push),
      .push_data (res_data),
      .pop       (out_pop),
      .head      (out_head),
      .full      (out_full),
      .empty     (out_empty),
      .count     (out_count)
   );

   // No bypass from res_data: an empty read leaves output_data untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         output_data <= '0;
         err_ovf     <= 1'b0;
         err_udf     <= 1'b0;
      end else begin
         if (out_pop) output_data <= out_head;
         if (clr_err)      err_ovf <= 1'b0;
         else if (ovf_set) err_ovf <= 1'b1;
         if (clr_err)      err_udf <= 1'b0;
         else if (udf_set) err_udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rmio_eu_buffer.sv
// Bench for rmio_eu_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_rmio_eu_buffer;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] input_data = '0;
   logic          input_we = 1'b0;
   logic          output_re = 1'b0;
   logic [DW-1:0] output_data;
   logic [DW-1:0] op_data;
   logic          op_valid;
   logic          op_ready = 1'b0;
   logic [DW-1:0] res_data = '0;
   logic          res_valid = 1'b0;
   logic          res_ready;
   logic [4:0]    in_count;
   logic [4:0]    out_count;
   logic          err_ovf;
   logic          err_udf;
   logic          clr_err = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state
   logic [DW-1:0] m_inq[$];
   logic [DW-1:0] m_outq[$];
   logic [DW-1:0] m_out_data;
   logic          m_ovf;
   logic          m_udf;

   rmio_eu_buffer #(
      .DATA_W    (DW),
      .IN_DEPTH  (DEPTH),
      .OUT_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .input_data  (input_data),
      .input_we    (input_we),
      .output_re   (output_re),
      .output_data (output_data),
      .op_data     (op_data),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .res_data    (res_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .in_count    (in_count),
      .out_count   (out_count),
      .err_ovf     (err_ovf),
      .err_udf     (err_udf),
      .clr_err     (clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_inq.delete();
      m_outq.delete();
      m_out_data = '0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
   endtask

   // Advances the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      bit in_pop, in_full, ovf_set, out_pop, udf_set, res_rdy;
      in_pop  = (m_inq.size() > 0) && op_ready;
      in_full = (m_inq.size() == DEPTH);
      ovf_set = input_we && in_full && !in_pop;
      res_rdy = (m_outq.size() != DEPTH);
      out_pop = output_re && (m_outq.size() > 0);
      udf_set = output_re && (m_outq.size() == 0);
      if (in_pop) void'(m_inq.pop_front());
      if (input_we && !ovf_set) m_inq.push_back(input_data);
      if (out_pop) m_out_data = m_outq.pop_front();
      if (res_valid && res_rdy) m_outq.push_back(res_data);
      if (clr_err) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (ovf_set) m_ovf = 1'b1;
         if (udf_set) m_udf = 1'b1;
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".op_valid"},  DW'(op_valid),  DW'(m_inq.size() > 0));
      if (m_inq.size() > 0) chk({ctx, ".op_data"}, op_data, m_inq[0]);
      chk({ctx, ".in_count"},  DW'(in_count),  DW'(m_inq.size()));
      chk({ctx, ".out_count"}, DW'(out_count), DW'(m_outq.size()));
      chk({ctx, ".res_ready"}, DW'(res_ready), DW'(m_outq.size() != DEPTH));
      chk({ctx, ".output_data"}, output_data, m_out_data);
      chk({ctx, ".err_ovf"},   DW'(err_ovf),   DW'(m_ovf));
      chk({ctx, ".err_udf"},   DW'(err_udf),   DW'(m_udf));
   endtask

   task automatic tick(input string ctx);
      // Handshake outputs must not depend combinationally on this cycle's inputs.
      chk({ctx, ".pre_op_valid"},  DW'(op_valid),  DW'(m_inq.size() > 0));
      chk({ctx, ".pre_res_ready"}, DW'(res_ready), DW'(m_outq.size() != DEPTH));
      model_step();
      @(posedge clk);
      #1;
      check_all(ctx);
   endtask

   task automatic idle();
      input_we  = 1'b0;
      output_re = 1'b0;
      op_ready  = 1'b0;
      res_valid = 1'b0;
      clr_err   = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] seq3 [3];
      seq3[0] = 32'h11;
      seq3[1] = 32'h22;
      seq3[2] = 32'h33;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Three writes streaming straight through to the EU
      op_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         input_we   = 1'b1;
         input_data = seq3[i];
         tick("stream");
         chk("stream.head", op_data, seq3[i]);
         chk("stream.cnt1", DW'(in_count), 32'd1);
      end
      input_we = 1'b0;
      tick("stream_drain");

      // Overflow then clear
      op_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         input_we   = 1'b1;
         input_data = 32'h100 + DW'(i);
         tick("fill");
      end
      chk("fill.count16", DW'(in_count), 32'd16);
      chk("fill.ovf", DW'(err_ovf), 32'd1);
      input_we = 1'b0;
      clr_err  = 1'b1;
      tick("clr_ovf");
      clr_err = 1'b0;
      tick("after_clr");

      // Simultaneous push/pop while full, across pointer wrap
      for (int i = 0; i < 20; i++) begin
         input_we   = 1'b1;
         op_ready   = 1'b1;
         input_data = 32'h200 + DW'(i);
         tick("full_pp");
      end
      chk("full_pp.no_ovf", DW'(err_ovf), 32'd0);
      input_we = 1'b0;
      for (int i = 0; i < 17; i++) tick("drain");

      // Single result and underflow
      idle();
      res_valid = 1'b1;
      res_data  = 32'hA5;
      tick("res_push");
      res_valid = 1'b0;
      output_re = 1'b1;
      tick("res_pop");
      chk("res_pop.a5", output_data, 32'hA5);
      tick("res_udf");
      chk("res_udf.hold", output_data, 32'hA5);
      chk("res_udf.flag", DW'(err_udf), 32'd1);
      output_re = 1'b0;
      clr_err   = 1'b1;
      tick("clr_udf");
      clr_err = 1'b0;

      // Output FIFO full back-pressure
      res_valid = 1'b1;
      for (int i = 0; i < 18; i++) begin
         res_data = 32'h300 + DW'(i);
         tick("res_fill");
      end
      chk("res_fill.not_ready", DW'(res_ready), 32'd0);
      output_re = 1'b1;
      tick("res_one_pop");
      output_re = 1'b0;
      chk("res_one_pop.ready", DW'(res_ready), 32'd1);
      res_valid = 1'b0;
      output_re = 1'b1;
      for (int i = 0; i < 17; i++) tick("res_drain");
      idle();
      clr_err = 1'b1;
      tick("clr_all");
      clr_err = 1'b0;

      // Async reset with traffic queued in both FIFOs
      input_we  = 1'b1;
      res_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         input_data = 32'h400 + DW'(i);
         res_data   = 32'h500 + DW'(i);
         tick("preload");
      end
      output_re = 1'b1;
      tick("preload_read");
      idle();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst        = 1'b0;
      input_we   = 1'b1;
      input_data = 32'h77;
      tick("post_rst");
      chk("post_rst.first", op_data, 32'h77);
      input_we = 1'b0;

      // Random traffic with varying pressure on each side
      for (int seg = 0; seg < 4; seg++) begin
         int unsigned p_we, p_rdy, p_rv, p_re;
         p_we  = (seg == 1) ? 90 : 50;
         p_rdy = (seg == 1) ? 20 : ((seg == 2) ? 90 : 50);
         p_rv  = (seg == 3) ? 90 : 50;
         p_re  = (seg == 3) ? 20 : ((seg == 2) ? 90 : 50);
         for (int i = 0; i < 150; i++) begin
            input_we   = ($urandom_range(0, 99) < p_we);
            input_data = $urandom;
            op_ready   = ($urandom_range(0, 99) < p_rdy);
            res_valid  = ($urandom_range(0, 99) < p_rv);
            res_data   = $urandom;
            output_re  = ($urandom_range(0, 99) < p_re);
            clr_err    = ($urandom_range(0, 99) < 5);
            tick("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
